// File: rtl/fir_capture_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_capture_buffer: multi-channel triggered capture RAM, pre-trigger     |
// | window, signed edge trigger. Optional macro: CAPTURE_DECIM_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_capture_buffer #(
  parameter int NB_DATA = 8,
  parameter int N_CH    = 2,
  parameter int DEPTH   = 256,
  parameter int PRETRIG = 64,
  parameter int TRIG_CH = 0
) (
  input  logic                         clk,
  input  logic                         i_srst,
  input  logic                         i_en,
  input  logic [N_CH*NB_DATA-1:0]      i_data,
  input  logic                         i_arm,
  input  logic                         i_force,
  input  logic [NB_DATA-1:0]           i_thresh,
  input  logic                         i_edge,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]                   i_decim,
`endif
  input  logic [$clog2(DEPTH)-1:0]     i_rd_addr,
  output logic [N_CH*NB_DATA-1:0]      o_rd_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(DEPTH)-1:0]     o_trig_idx
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_dw = N_CH * NB_DATA;
  localparam logic [c_aw-1:0] c_one       = c_aw'(1);
  localparam logic [c_aw-1:0] c_pretrig   = c_aw'(PRETRIG);
  localparam logic [c_aw-1:0] c_pre_last  = c_aw'(PRETRIG - 1);
  localparam logic [c_aw-1:0] c_post_last = c_aw'(DEPTH - PRETRIG - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_aw-1:0]           r_wr_ptr;
  logic [c_aw-1:0]           r_cnt;
  logic [c_aw-1:0]           r_trig_idx;
  logic signed [NB_DATA-1:0] r_prev;
  logic                      r_force_pend;
  logic [c_dw-1:0]           r_rd_data;
  logic [c_dw-1:0]           r_mem [DEPTH];

  logic                      w_busy;
  logic                      w_accept;
  logic                      w_decim_ok;
  logic                      w_start;
  logic                      w_rise;
  logic                      w_fall;
  logic                      w_trig;
  logic signed [NB_DATA-1:0] w_s;
  logic signed [NB_DATA-1:0] w_thr;
  logic [c_aw-1:0]           w_rd_phys;

  assign w_busy   = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_accept = i_en && w_decim_ok && w_busy;

  assign w_s   = i_data[TRIG_CH*NB_DATA +: NB_DATA];
  assign w_thr = i_thresh;
  assign w_rise = (r_prev < w_thr) && (w_s >= w_thr);
  assign w_fall = (r_prev > w_thr) && (w_s <= w_thr);
  // A force seen on an idle cycle is held until the next accepted sample.
  assign w_trig = w_accept && ((i_edge ? w_fall : w_rise) || i_force || r_force_pend);

`ifdef CAPTURE_DECIM_EN
  logic [7:0] r_decim_cnt;

  assign w_decim_ok = (r_decim_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (i_srst || w_start) begin
      r_decim_cnt <= 8'd0;
    end else if (w_busy && i_en) begin
      r_decim_cnt <= (r_decim_cnt >= i_decim) ? 8'd0 : r_decim_cnt + 8'd1;
    end
  end
`else
  assign w_decim_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_arm) begin
          w_start     = 1'b1;
          w_state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        if (w_accept && (r_cnt == c_pre_last)) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_trig) w_state_nxt = S_POST;
      end
      S_POST: begin
        if (w_accept && (r_cnt == c_post_last)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (i_arm) begin
          w_start     = 1'b1;
          w_state_nxt = S_PRE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_trig_idx   <= '0;
      r_prev       <= '0;
      r_force_pend <= 1'b0;
    end else if (w_start) begin
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_force_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + c_one;
        r_prev   <= w_s;
      end
      case (r_state)
        S_PRE: begin
          if (w_accept) r_cnt <= (r_cnt == c_pre_last) ? '0 : r_cnt + c_one;
        end
        S_WAIT: begin
          if (w_trig) begin
            r_trig_idx   <= r_wr_ptr;
            r_cnt        <= '0;
            r_force_pend <= 1'b0;
          end else if (i_force) begin
            r_force_pend <= 1'b1;
          end
        end
        S_POST: begin
          if (w_accept) r_cnt <= r_cnt + c_one;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= i_data;
  end

  // Logical index 0 is the oldest pre-trigger sample; modulo wrap is implicit.
  assign w_rd_phys = r_trig_idx - c_pretrig + i_rd_addr;

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[w_rd_phys];
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_busy     = w_busy;
  assign o_done     = (r_state == S_DONE);
  assign o_trig_idx = r_trig_idx;

endmodule
`default_nettype wire

// File: tb/tb_fir_capture_buffer.sv
`default_nettype none
// Directed table-driven bench for fir_capture_buffer (DEPTH=16, PRETRIG=4).
module tb_fir_capture_buffer;

  logic        clk = 1'b0;
  logic        srst, en, arm, frc, edge_sel;
  logic [15:0] data;
  logic [7:0]  thresh;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy, done;
  logic [3:0]  trig_idx;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]  decim;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;
  rd_vec_t tbl [16];

  fir_capture_buffer #(
    .NB_DATA(8), .N_CH(2), .DEPTH(16), .PRETRIG(4), .TRIG_CH(0)
  ) dut (
    .clk       (clk),
    .i_srst    (srst),
    .i_en      (en),
    .i_data    (data),
    .i_arm     (arm),
    .i_force   (frc),
    .i_thresh  (thresh),
    .i_edge    (edge_sel),
`ifdef CAPTURE_DECIM_EN
    .i_decim   (decim),
`endif
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_busy    (busy),
    .o_done    (done),
    .o_trig_idx(trig_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pk(int a, int b);
    return {b[7:0], a[7:0]};
  endfunction

  task automatic send(int c0, int c1);
    data = pk(c0, c1);
    en   = 1'b1;
    tick;
    en   = 1'b0;
  endtask

  task automatic arm_pulse;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task automatic run_tbl(string nm);
    for (int i = 0; i < 16; i++) begin
      rd_addr = tbl[i].addr;
      tick;
      chk($sformatf("%s_rd%0d", nm, i), rd_data, tbl[i].exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; en = 1'b0; arm = 1'b0; frc = 1'b0; edge_sel = 1'b0;
    data = '0; thresh = '0; rd_addr = '0;
`ifdef CAPTURE_DECIM_EN
    decim = 8'd0;
`endif
    tick; tick;
    srst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig", trig_idx, 0);
    chk("rst_rd", rd_data, 0);

    // Reset while in POST aborts the capture
    thresh = 8'd5; edge_sel = 1'b0;
    arm_pulse;
    for (int v = -20; v <= 8; v++) send(v, ~v);
    chk("midpost_busy", busy, 1);
    srst = 1'b1;
    tick;
    chk("midpost_rst_busy", busy, 0);
    chk("midpost_rst_done", done, 0);
    chk("midpost_rst_trig", trig_idx, 0);
    srst = 1'b0;

    // Rising ramp through threshold 5
    arm_pulse;
    chk("ramp_busy_rise", busy, 1);
    for (int v = -20; v <= 15; v++) send(v, ~v);
    chk("ramp_busy_pre_last", busy, 1);
    chk("ramp_done_pre_last", done, 0);
    chk("ramp_trig", trig_idx, 9);
    send(16, ~16);
    chk("ramp_done", done, 1);
    chk("ramp_busy_fall", busy, 0);
    send(17, ~17);
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].exp  = pk(1 + i, ~(1 + i));
    end
    run_tbl("ramp");

    // Falling ramp through -3
    thresh = 8'hFD; edge_sel = 1'b1;
    arm_pulse;
    for (int v = 20; v >= -13; v--) send(v, ~v);
    chk("desc_done_early", done, 0);
    send(-14, ~(-14));
    chk("desc_done", done, 1);
    chk("desc_trig", trig_idx, 7);
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].exp  = pk(1 - i, ~(1 - i));
    end
    run_tbl("desc");

    // Forced trigger after long wait with pointer wrap
    thresh = 8'd10; edge_sel = 1'b0;
    arm_pulse;
    for (int k = 0; k <= 43; k++) send(0, k);
    chk("force_wait_busy", busy, 1);
    chk("force_wait_trig_held", trig_idx, 7);
    frc = 1'b1;
    send(0, 44);
    frc = 1'b0;
    for (int k = 45; k <= 55; k++) send(0, k);
    chk("force_done", done, 1);
    chk("force_trig", trig_idx, 12);
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].exp  = pk(0, 40 + i);
    end
    run_tbl("force");

    // Gapped strobe, re-arm attempt while waiting
    thresh = 8'd8; edge_sel = 1'b0;
    arm_pulse;
    for (int k = 0; k <= 19; k++) begin
      data = pk(k, k + 100);
      en   = 1'b1;
      arm  = (k == 6);
      tick;
      if (k == 18) chk("gap_done_early", done, 0);
      if (k == 19) chk("gap_done", done, 1);
      en   = 1'b0;
      data = pk(127, 0);
      tick;
      arm  = 1'b0;
    end
    chk("gap_trig", trig_idx, 8);
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].exp  = pk(4 + i, 104 + i);
    end
    run_tbl("gap");

`ifdef CAPTURE_DECIM_EN
    // Decimation by 3: only every third strobe stored
    decim = 8'd2; thresh = 8'd1; edge_sel = 1'b0;
    arm_pulse;
    for (int n = 0; n <= 65; n++) send(-30 + n, n);
    chk("decim_done_early", done, 0);
    send(36, 66);
    chk("decim_done", done, 1);
    chk("decim_trig", trig_idx, 11);
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].exp  = pk(-9 + 3 * i, 21 + 3 * i);
    end
    run_tbl("decim");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_capture_buffer.md
# fir_capture_buffer

Parametrised multi-channel triggered capture buffer for the FIR demonstrator datapath; successor to the ILA-based observation in the current top level. Samples N_CH channels (raw generator output, filtered output, further taps) into on-chip RAM with a pre-trigger window and a signed threshold/edge trigger. The buffer is read back in chronological order through a synchronous read port. It sits beside `filtro_fir`, clocked and reset with it.

## Interface

- NB_DATA, 8, width of one channel sample (signed two's complement)
- N_CH, 2, number of captured channels
- DEPTH, 256, samples per channel; power of two, ≥ 4
- PRETRIG, 64, samples kept before trigger; 1 ≤ PRETRIG ≤ DEPTH-2
- TRIG_CH, 0, channel index compared against threshold
- clk  in  1  clock, all logic rising-edge
- i_srst  in  1  synchronous reset, active-high
- i_en  in  1  sample strobe; i_data captured only when high
- i_data  in  N_CH*NB_DATA  channel k at bits [k*NB_DATA +: NB_DATA]
- i_arm  in  1  start capture (pulse)
- i_force  in  1  force trigger while waiting
- i_thresh  in  NB_DATA  signed trigger threshold
- i_edge  in  1  0 = rising, 1 = falling
- i_rd_addr  in  log2(DEPTH)  logical read index, 0 = oldest sample
- o_rd_data  out  N_CH*NB_DATA  read data
- o_busy  out  1  high in PRE, WAIT, POST
- o_done  out  1  high in DONE
- o_trig_idx  out  log2(DEPTH)  physical RAM address of trigger sample

## Operation

- Accepted sample: i_en=1 (and decimation condition, see Configuration) in a busy state; written at wr_ptr, wr_ptr increments mod DEPTH.
- States IDLE, PRE, WAIT, POST, DONE.
- IDLE: nothing written. i_arm → PRE; wr_ptr, counters, prev-sample register cleared.
- PRE: writes PRETRIG accepted samples, no trigger evaluation; after the PRETRIG-th → WAIT.
- WAIT: continuous circular writing. Trigger on accepted sample s with previous accepted sample p on TRIG_CH: rising = p < thresh and s ≥ thresh; falling = p > thresh and s ≤ thresh; signed compare. i_force=1 on any cycle in WAIT also triggers (on the current accepted sample if i_en, otherwise on the next accepted sample). Force and natural trigger together = single trigger. Trigger sample is written; its address latched into o_trig_idx → POST.
- POST: writes DEPTH-PRETRIG-1 more accepted samples → DONE. Total post-trigger samples including trigger sample = DEPTH-PRETRIG.
- DONE: no writes. i_arm → PRE (re-arm). o_trig_idx and RAM held.
- i_arm in PRE/WAIT/POST ignored.
- Readback: physical = (o_trig_idx - PRETRIG + i_rd_addr) mod DEPTH; logical index PRETRIG = trigger sample; DEPTH-1 = newest. Wrap-around of pointer and read address handled internally.
- Reset: state IDLE, o_busy=0, o_done=0, o_trig_idx=0, o_rd_data=0, counters cleared; RAM contents not reset. Reset mid-capture aborts without completing.

## Timing

- State, counters and o_trig_idx update at the clock edge ending the cycle in which the sample is accepted.
- o_busy rises the cycle after i_arm sampled; o_done rises the cycle after the last POST write; o_busy falls same edge.
- Read latency 1: o_rd_data reflects i_rd_addr of previous cycle; valid in any state, meaningful in DONE.
- Write/read same address same cycle: read returns old data.
- Throughput: one sample per clock when i_en held high.

## Configuration

- CAPTURE_DECIM_EN defined: adds port i_decim in 8 (held stable while busy); only every (i_decim+1)-th i_en pulse is accepted, first i_en after arm accepted; decimation counter cleared on arm and reset. i_decim=0 equals no decimation. Trigger compares consecutive accepted samples only.
- Not defined: no i_decim port; every i_en sample accepted.

## Test plan

Bench: NB_DATA=8, N_CH=2, DEPTH=16, PRETRIG=4, TRIG_CH=0.
- Reset asserted mid-POST -> next cycle o_busy=0, o_done=0, o_trig_idx=0; subsequent arm captures normally.
- Arm, i_en=1, ch0 ramp -20,-19,…, ch1 = ~ch0, thresh=5 rising -> trigger on ch0=5; o_done after 12 post samples; logical reads 0..15 return ch0 1..16, ch1 inverted.
- Same ramp descending from 20, i_edge=1, thresh=-3 -> trigger sample -3 at logical index 4.
- Constant ch0=0, thresh=10, WAIT for 40 samples (pointer wraps twice), i_force pulse -> sample at force is logical index 4, indices 0..3 are the four preceding samples.
- i_en toggling every other cycle, i_arm pulsed during WAIT -> ignored; capture completes with exactly 16 samples, none duplicated.
- CAPTURE_DECIM_EN, i_decim=2, ramp +1 per i_en -> stored samples step by 3; trigger only on decimated crossing.
